// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler and period counter with per-channel
// compare and polarity. Configuration is double-buffered and applied only at period boundaries.
module pwm_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic                    center_mode,
  input  logic [NUM_CH-1:0]       invert,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    period_tick,
  output logic                    load_ack
);

  // Handshake: load is a single-cycle strobe with no back-pressure; every load is
  // accepted into the pending set. load_ack pulses once when that set becomes active.

  logic [DIV_W-1:0]        pc;
  logic [CNT_W-1:0]        cnt;
  logic                    dir_down;

  logic                    pend;
  logic [CNT_W-1:0]        pend_period;
  logic [NUM_CH*CNT_W-1:0] pend_duty;
  logic                    pend_center;
  logic [NUM_CH-1:0]       pend_invert;

  logic [CNT_W-1:0]        act_period;
  logic [NUM_CH*CNT_W-1:0] act_duty;
  logic                    act_center;
  logic [NUM_CH-1:0]       act_invert;

  logic [CNT_W-1:0]        last;
  logic                    tick;
  logic                    at_top;
  logic                    boundary;
  logic                    apply;
  logic [NUM_CH-1:0]       raw;

  // A period of 0 behaves as 1, so the top count is 0 in that case.
  // The >= in tick keeps the prescaler from running the full range if prescale is lowered live.
  always_comb begin
    last     = (act_period == '0) ? '0 : act_period - CNT_W'(1);
    tick     = enable && (pc >= prescale);
    at_top   = (cnt == last);
    boundary = tick && (act_center ? (dir_down && (cnt == '0)) : at_top);
    apply    = pend && (boundary || !enable);
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = enable && (cnt < act_duty[i*CNT_W +: CNT_W]);
    end
  end

  // Center mode holds each end value for two ticks by flipping dir without moving cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= '0;
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!enable) begin
      pc       <= '0;
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (tick) begin
      pc <= '0;
      if (boundary) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (act_center && !dir_down && at_top) begin
        dir_down <= 1'b1;
      end else if (act_center && dir_down) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      pc <= pc + DIV_W'(1);
    end
  end

  // A load coinciding with an apply becomes the next pending set; the old one goes active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend        <= 1'b0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_center <= 1'b0;
      pend_invert <= '0;
      act_period  <= CNT_W'(1);
      act_duty    <= '0;
      act_center  <= 1'b0;
      act_invert  <= '0;
    end else begin
      if (load) begin
        pend        <= 1'b1;
        pend_period <= period;
        pend_duty   <= duty;
        pend_center <= center_mode;
        pend_invert <= invert;
      end else if (apply) begin
        pend <= 1'b0;
      end
      if (apply) begin
        act_period <= pend_period;
        act_duty   <= pend_duty;
        act_center <= pend_center;
        act_invert <= pend_invert;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm         <= '0;
      period_tick <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      pwm         <= raw ^ act_invert;
      period_tick <= boundary;
      load_ack    <= apply;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: configures via load, captures per-clock output
// bit vectors and compares them against hand-computed patterns.
module tb_pwm_multi_ch;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int DIV_W  = 8;

  logic                    clk;
  logic                    reset_n;
  logic                    enable;
  logic [DIV_W-1:0]        prescale;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic                    center_mode;
  logic [NUM_CH-1:0]       invert;
  logic                    load;
  logic [NUM_CH-1:0]       pwm;
  logic                    period_tick;
  logic                    load_ack;

  int n_total;
  int n_bad;

  logic [63:0] cap_pwm [NUM_CH];
  logic [63:0] cap_tick;
  logic [63:0] cap_ack;

  pwm_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .prescale   (prescale),
    .period     (period),
    .duty       (duty),
    .center_mode(center_mode),
    .invert     (invert),
    .load       (load),
    .pwm        (pwm),
    .period_tick(period_tick),
    .load_ack   (load_ack)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit j of each capture vector is the output sampled just after the j-th following edge.
  task automatic capture(input int n);
    for (int c = 0; c < NUM_CH; c++) cap_pwm[c] = '0;
    cap_tick = '0;
    cap_ack  = '0;
    for (int j = 0; j < n; j++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) cap_pwm[c][j] = pwm[c];
      cap_tick[j] = period_tick;
      cap_ack[j]  = load_ack;
    end
  endtask

  // Loads a configuration with the counter disabled: ack must appear exactly one clk later.
  task automatic cfg_load(input logic [DIV_W-1:0] ps, input logic [CNT_W-1:0] per,
                          input logic [NUM_CH*CNT_W-1:0] d, input logic cm,
                          input logic [NUM_CH-1:0] inv);
    enable      = 1'b0;
    prescale    = ps;
    period      = per;
    duty        = d;
    center_mode = cm;
    invert      = inv;
    load        = 1'b1;
    step();
    load = 1'b0;
    check("ack_not_early", {63'd0, load_ack}, 64'd0);
    step();
    check("ack_after_load", {63'd0, load_ack}, 64'd1);
    check("no_tick_on_disabled_load", {63'd0, period_tick}, 64'd0);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    prescale    = '0;
    period      = '0;
    duty        = '0;
    center_mode = 1'b0;
    invert      = '0;
    load        = 1'b0;
    repeat (2) step();
    check("reset_pwm", {60'd0, pwm}, 64'd0);
    check("reset_tick", {63'd0, period_tick}, 64'd0);
    check("reset_ack", {63'd0, load_ack}, 64'd0);
    reset_n = 1'b1;
    step();

    // edge-aligned P=10 duty 3
    cfg_load(8'd0, 16'd10, {16'd0, 16'd0, 16'd0, 16'd3}, 1'b0, 4'b0000);
    enable = 1'b1;
    capture(20);
    check("edge_pwm0", cap_pwm[0], 64'h01C07);
    check("edge_tick", cap_tick, 64'h80200);
    check("edge_ack", cap_ack, 64'h0);

    // two loads mid-period (cnt 4 and 5): last one wins at the boundary, single ack
    repeat (4) step();
    duty = {16'd0, 16'd0, 16'd0, 16'd5};
    load = 1'b1;
    step();
    duty = {16'd0, 16'd0, 16'd0, 16'd7};
    step();
    load = 1'b0;
    capture(20);
    check("shadow_pwm0", cap_pwm[0], 64'hFC7F0);
    check("shadow_tick", cap_tick, 64'h2008);
    check("shadow_ack", cap_ack, 64'h8);

    // center-aligned P=4 duty 2
    cfg_load(8'd0, 16'd4, {16'd0, 16'd0, 16'd0, 16'd2}, 1'b1, 4'b0000);
    enable = 1'b1;
    capture(16);
    check("center_pwm0", cap_pwm[0], 64'hC3C3);
    check("center_tick", cap_tick, 64'h8080);

    // extremes and polarity
    cfg_load(8'd0, 16'd10, {16'd3, 16'hFFFF, 16'd10, 16'd0}, 1'b0, 4'b1000);
    enable = 1'b1;
    capture(20);
    check("duty_zero", cap_pwm[0], 64'h0);
    check("duty_eq_p", cap_pwm[1], 64'hFFFFF);
    check("duty_max", cap_pwm[2], 64'hFFFFF);
    check("inverted", cap_pwm[3], 64'hFE3F8);
    check("extreme_tick", cap_tick, 64'h80200);

    // prescale 4 stretches every tick to 5 clk
    cfg_load(8'd4, 16'd4, {16'd0, 16'd0, 16'd0, 16'd1}, 1'b0, 4'b0000);
    enable = 1'b1;
    capture(40);
    check("presc_pwm0", cap_pwm[0], 64'h1F0001F);
    check("presc_tick", cap_tick, 64'h80_0008_0000);

    // period 0 behaves as period 1
    cfg_load(8'd0, 16'd0, {16'd0, 16'd0, 16'd0, 16'd1}, 1'b0, 4'b0000);
    enable = 1'b1;
    capture(8);
    check("p0_pwm0", cap_pwm[0], 64'hFF);
    check("p0_tick", cap_tick, 64'hFF);

    // disabled: outputs equal invert, no ticks; then restart from cnt 0
    cfg_load(8'd0, 16'd10, {16'd0, 16'd0, 16'd5, 16'd0}, 1'b0, 4'b0010);
    capture(10);
    check("dis_pwm0", cap_pwm[0], 64'h0);
    check("dis_pwm1", cap_pwm[1], 64'h3FF);
    check("dis_tick", cap_tick, 64'h0);
    enable = 1'b1;
    capture(10);
    check("reen_pwm1", cap_pwm[1], 64'h3E0);
    check("reen_tick", cap_tick, 64'h200);

    // asynchronous reset mid-period
    cfg_load(8'd0, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 4'b0000);
    enable = 1'b1;
    step();
    step();
    check("pre_reset_pwm", {60'd0, pwm}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pwm", {60'd0, pwm}, 64'h0);
    check("async_tick", {63'd0, period_tick}, 64'h0);
    check("async_ack", {63'd0, load_ack}, 64'h0);
    #2;
    reset_n = 1'b1;
    capture(10);
    check("post_reset_pwm0", cap_pwm[0], 64'h0);
    check("post_reset_tick", cap_tick, 64'h3FF);
    check("post_reset_ack", cap_ack, 64'h0);
    cfg_load(8'd0, 16'd10, {16'd0, 16'd0, 16'd0, 16'd5}, 1'b0, 4'b0000);
    enable = 1'b1;
    capture(10);
    check("reload_pwm0", cap_pwm[0], 64'h1F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator. NUM_CH outputs share one prescaler and one period counter. Each channel has its own duty compare and output polarity. The counter runs edge-aligned (up) or center-aligned (up/down). Duty, period, mode and polarity are double-buffered: a software load takes effect only at a period boundary, so outputs never glitch. Sits between the register/control logic and motor, servo and LED pins, and replaces the per-channel single-frequency counters.

## Interface
Reset scheme (already decided): one clock; reset is asynchronous and active-low.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16)
- CNT_W, 16, width of period/duty/counter
- DIV_W, 8, width of prescaler

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run counter; 0 = hold counter at 0, outputs inactive
- prescale  in  DIV_W  tick every prescale+1 clk (live, not shadowed)
- period  in  CNT_W  counter length P (0 treated as 1)
- duty  in  NUM_CH*CNT_W  channel i duty in bits [i*CNT_W +: CNT_W]
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned
- invert  in  NUM_CH  per-channel output polarity
- load  in  1  one-cycle strobe; captures period/duty/center_mode/invert into pending regs
- pwm  out  NUM_CH  PWM outputs, registered
- period_tick  out  1  one-cycle pulse at each period boundary
- load_ack  out  1  one-cycle pulse when pending values become active

## Operation
- Prescaler pc counts 0..prescale. tick = (pc == prescale). pc wraps to 0 on tick. prescale = 0 gives tick every clk.
- Edge mode: cnt goes 0,1,..,P-1,0 on ticks. Period = P ticks. Boundary = tick with cnt == P-1.
- Center mode: cnt goes up 0..P-1, then down P-1..0; each end value is held for 2 ticks (dir flips without changing cnt). Period = 2P ticks. Boundary = tick with cnt == 0 and dir = down.
- Channel raw = (cnt < duty_act[i]). duty 0 gives constant 0. duty >= P gives constant 1 (100%).
- pwm[i] = raw XOR invert_act[i].
- load: captures all shadowed inputs into pending and sets pend. A second load before the boundary overwrites pending; only one load_ack is issued.
- At a boundary with pend = 1: copy pending to active, clear pend, pulse load_ack together with period_tick. cnt restarts at 0, dir = up.
- enable = 0: pc, cnt and dir held at 0/up. pwm = invert_act. A pending load is applied on the next clk, with load_ack and no period_tick. When enable rises, counting starts from cnt = 0.
- load and boundary in the same cycle: the boundary applies the old pending set (if any). The new values become pending for the next boundary.
- Mode change takes effect only through load/boundary; no partial periods.

## Timing
- Reset values: pwm = 0, period_tick = 0, load_ack = 0. pc = cnt = 0, dir = up, pend = 0. Active duty = 0, period = 1, center = 0, invert = 0.
- pwm, period_tick and load_ack are registered. pwm reflects the cnt/active values of the previous clk (1-clk latency).
- load is sampled on the clk edge. Earliest load_ack is 1 clk later when enable = 0. Otherwise it comes at the next boundary.
- Reset assertion mid-period forces all outputs low immediately (async). Pending and active values are lost.
- Counter and compare widths are CNT_W. No overflow is possible because cnt <= P-1.

## Test plan
- Edge basic: prescale=0, period=10, duty0=3, enable=1 → pwm[0] repeats 3 clk high / 7 low; period_tick every 10 clk.
- Center: prescale=0, period=4, duty0=2, center_mode=1 → 8-clk period, pwm[0] high 4 clk, symmetric about cnt=0; period_tick every 8 clk.
- Shadow load mid-period: running duty0=3/P=10; pulse load with duty0=7 at cnt=5 → current period unchanged; load_ack with period_tick; next period high 7 clk.
- Extremes and polarity: duty=0 → constant 0; duty=P and duty=0xFFFF → constant 1; invert=1 → complement; prescale=4 → all periods ×5.
- Disable: enable=0, invert[1]=1, load duty → pwm = invert, load_ack 1 clk after load, no period_tick. Re-enable → first period starts at cnt=0.
- Async reset mid-period: assert reset_n=0 for 3 ns → pwm = 0 immediately. After release, active duty = 0 and pwm stays 0 until a load is applied.
